// File: rtl/serv_ifetch.sv
// serv_ifetch: Wishbone-classic instruction fetch initiator.
// Issues one read per accepted fetch request and hands instruction bits
// [31:2] to the decoder with a one-cycle strobe. Rejects misaligned PCs,
// flags non-32-bit encodings, aborts on bus timeout and honours flushes.
module serv_ifetch #(
    parameter int unsigned TIMEOUT  = 0,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        i_rst,
    input  logic        i_fetch_req,
    input  logic [31:0] i_pc,
    input  logic        i_flush,
    output logic [31:0] o_ibus_adr,
    output logic        o_ibus_cyc,
    input  logic        i_ibus_ack,
    input  logic [31:0] i_ibus_rdt,
    output logic [29:0] o_wb_rdt,
    output logic        o_wb_en,
    output logic        o_busy,
    output logic        o_misalign,
    output logic        o_illegal,
    output logic        o_bus_err
);

    // A zero TIMEOUT still needs a legal (1-bit) counter; it is simply unused.
    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t      state_reg, state_next;
    logic [29:0] adr_reg, adr_next;
    logic [29:0] rdt_reg, rdt_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic        en_reg, en_next;
    logic        ill_reg, ill_next;
    logic        mis_reg, mis_next;
    logic        err_reg, err_next;

    // State and output registers; synchronous reset discards any ack seen this cycle.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_reg <= IDLE;
            adr_reg   <= RESET_PC[31:2];
            rdt_reg   <= '0;
            cnt_reg   <= '0;
            en_reg    <= 1'b0;
            ill_reg   <= 1'b0;
            mis_reg   <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            adr_reg   <= adr_next;
            rdt_reg   <= rdt_next;
            cnt_reg   <= cnt_next;
            en_reg    <= en_next;
            ill_reg   <= ill_next;
            mis_reg   <= mis_next;
            err_reg   <= err_next;
        end
    end

    // Next-state logic: accept requests in IDLE; in WAIT flush beats ack beats timeout.
    always_comb begin
        state_next = state_reg;
        adr_next   = adr_reg;
        rdt_next   = rdt_reg;
        cnt_next   = cnt_reg;
        en_next    = 1'b0;
        ill_next   = 1'b0;
        mis_next   = 1'b0;
        err_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (i_fetch_req && !i_flush) begin
                    if (i_pc[1:0] == 2'b00) begin
                        adr_next   = i_pc[31:2];
                        cnt_next   = '0;
                        state_next = WAIT;
                    end else begin
                        mis_next = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (i_flush) begin
                    state_next = IDLE;
                end else if (i_ibus_ack) begin
                    rdt_next   = i_ibus_rdt[31:2];
                    en_next    = 1'b1;
                    ill_next   = (i_ibus_rdt[1:0] != 2'b11);
                    state_next = IDLE;
                end else if ((TIMEOUT != 0) && (cnt_reg == CNT_LAST)) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else if (cnt_reg != CNT_MAX) begin
                    // Saturate so the counter never wraps when the timeout is disabled.
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign o_ibus_adr = {adr_reg, 2'b00};
    assign o_ibus_cyc = (state_reg == WAIT);
    assign o_busy     = (state_reg == WAIT);
    assign o_wb_rdt   = rdt_reg;
    assign o_wb_en    = en_reg;
    assign o_illegal  = ill_reg;
    assign o_misalign = mis_reg;
    assign o_bus_err  = err_reg;

endmodule
